fft_agu: RTL and testbench
==========================

FFT_AGU -- requirements
Module: fft_agu

Interface
REQ-001 SHALL have parameter LOG_N, default 11, log2 of FFT length N (N = 2048).
REQ-002 SHALL have parameter WR_LAT, default 2, cycles from read-address issue to write-back of the same butterfly (at least 1).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin one in-place radix-2 DIT transform.
REQ-006 SHALL have port busy, output, 1, high from the first RUN cycle through the last DRAIN cycle.
REQ-007 SHALL have port done, output, 1, one-cycle pulse on transform completion.
REQ-008 SHALL have ports rd_addr_a and rd_addr_b, output, LOG_N each, sample-RAM read addresses for the butterfly a and b operands.
REQ-009 SHALL have port rd_valid, output, 1, read addresses valid this cycle.
REQ-010 SHALL have port tw_addr, output, LOG_N-1, twiddle ROM address, aligned with rd_addr_a.
REQ-011 SHALL have ports wr_addr_a and wr_addr_b, output, LOG_N each, write-back addresses for the butterfly aout and bout results.
REQ-012 SHALL have port wr_en, output, 1, write strobe for both write ports.
REQ-013 SHALL have port stall, input, 1, present only when FFT_AGU_STALL_EN is defined (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN and DONE, with registered stage counter s (0..LOG_N-1), butterfly counter i (0..N/2-1) and drain counter d.
REQ-015 SHALL, in IDLE, move to RUN with s=0 and i=0 when start=1.
REQ-016 SHALL ignore start in every state other than IDLE; there is no queuing.
REQ-017 SHALL, in each RUN cycle, assert rd_valid=1 and increment i; when i=N/2-1 it SHALL clear i, set d=0 and move to DRAIN.
REQ-018 SHALL hold DRAIN for exactly WR_LAT cycles with rd_valid=0, preventing a read-after-write hazard across stages.
REQ-019 SHALL, at the end of DRAIN, move to DONE if s=LOG_N-1, otherwise increment s and return to RUN.
REQ-020 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE.
REQ-021 SHALL generate the following addresses, where half=2^s, grp=i>>s and pos=i&(half-1):
- rd_addr_a = grp*2^(s+1) + pos
- rd_addr_b = rd_addr_a + half
- tw_addr = pos << (LOG_N-1-s)
- all values unsigned; no overflow is possible.
REQ-022 SHALL register rd_addr_a, rd_addr_b, tw_addr and rd_valid, so they are driven in the same cycle the FSM is in RUN with the corresponding i.
REQ-023 SHALL produce wr_addr_a, wr_addr_b and wr_en as rd_addr_a, rd_addr_b and rd_valid delayed by exactly WR_LAT cycles through a shift register.
REQ-024 SHALL keep busy high for exactly LOG_N*(N/2+WR_LAT) cycles, with done in the following cycle.
REQ-025 SHALL assume input data is already stored in bit-reversed order; this block performs no reordering.

Reset
REQ-026 SHALL, on reset_n=0, immediately force: state IDLE; s, i and d to 0; the delay line cleared; all outputs 0.
REQ-027 SHALL, when reset is asserted mid-transform, abandon the transform: no done pulse, and wr_en=0 from the reset assertion onward.
REQ-028 SHALL release reset synchronously to clk, with the first start accepted on the first edge after deassertion.

Configuration
REQ-029 SHALL, when FFT_AGU_STALL_EN is defined, add the stall input with this behaviour:
- stall=1 in RUN freezes i and s and forces rd_valid=0 for that cycle;
- the write delay line keeps shifting, so in-flight writes complete;
- stall is ignored in IDLE, DRAIN and DONE;
- busy stays high while stalled.
REQ-030 SHALL, when FFT_AGU_STALL_EN is undefined, have no stall port and behave as if stall=0.

Verification
REQ-031 SHALL cover: LOG_N=11, start pulse -> first RUN cycle gives rd_addr_a=0, rd_addr_b=1, tw_addr=0, rd_valid=1.
REQ-032 SHALL cover: LOG_N=11, stage s=1 with i=1 -> rd_addr_a=1, rd_addr_b=3, tw_addr=512; stage s=10 with i=5 -> rd_addr_a=5, rd_addr_b=1029, tw_addr=5.
REQ-033 SHALL cover: LOG_N=3, WR_LAT=2, start -> busy high for 18 cycles, 12 rd_valid and 12 wr_en pulses, each wr address equal to the rd address 2 cycles earlier, then a single done pulse.
REQ-034 SHALL cover: start held high for the whole transform -> exactly one transform and one done, with no restart until start is seen again in IDLE.
REQ-035 SHALL cover: reset_n pulled low at stage 2, i=100 -> all outputs 0 immediately, no done; a later start restarts at s=0, i=0.
REQ-036 SHALL cover, with FFT_AGU_STALL_EN defined: stall=1 for 3 cycles mid-RUN -> rd_valid=0 and addresses frozen for those 3 cycles, pending writes still issued, busy extended by 3 cycles.

Source files
------------

// File: rtl/fft_agu_if.sv
// FFT address-generator bus: start/busy/done, read, twiddle and write-back addresses.
// Optional stall input exists only when FFT_AGU_STALL_EN is defined.
interface fft_agu_if #(
  parameter int LOG_N = 11
);
  logic             start;
  logic             busy;
  logic             done;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic             rd_valid;
  logic [LOG_N-2:0] tw_addr;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;
  logic             wr_en;
`ifdef FFT_AGU_STALL_EN
  logic             stall;

  modport master (
    output start, stall,
    input  busy, done, rd_addr_a, rd_addr_b, rd_valid,
    input  tw_addr, wr_addr_a, wr_addr_b, wr_en
  );

  modport slave (
    input  start, stall,
    output busy, done, rd_addr_a, rd_addr_b, rd_valid,
    output tw_addr, wr_addr_a, wr_addr_b, wr_en
  );
`else
  modport master (
    output start,
    input  busy, done, rd_addr_a, rd_addr_b, rd_valid,
    input  tw_addr, wr_addr_a, wr_addr_b, wr_en
  );

  modport slave (
    input  start,
    output busy, done, rd_addr_a, rd_addr_b, rd_valid,
    output tw_addr, wr_addr_a, wr_addr_b, wr_en
  );
`endif
endinterface

// File: rtl/fft_agu.sv
// In-place radix-2 DIT FFT address generator with write-back delay line.
// Optional run-time stall input enabled by defining FFT_AGU_STALL_EN.
module fft_agu #(
  parameter int LOG_N  = 11,
  parameter int WR_LAT = 2
) (
  input logic    clk,
  input logic    reset_n,
  fft_agu_if.slave bus
);

  localparam int NH = LOG_N - 1;
  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int DW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [SW-1:0]    s;
  logic [NH-1:0]    i;
  logic [DW-1:0]    d;
  logic [LOG_N-1:0] ra;
  logic [LOG_N-1:0] rb;
  logic [NH-1:0]    tw;
  logic             vq;
  logic             busy_q;
  logic             done_q;
  logic             stl;
  logic             rv;

  logic [WR_LAT-1:0] wv;
  logic [LOG_N-1:0]  wa [WR_LAT];
  logic [LOG_N-1:0]  wb [WR_LAT];

`ifdef FFT_AGU_STALL_EN
  assign stl = bus.stall & (state == RUN);
`else
  assign stl = 1'b0;
`endif

  // A stalled RUN cycle issues no read; addresses stay frozen
  assign rv = vq & ~stl;

  // Butterfly addresses: a = i with bit s inserted as 0, b = a with bit s set
  function automatic logic [3*LOG_N-2:0] gen(
    input logic [SW-1:0] st,
    input logic [NH-1:0] bi
  );
    logic [LOG_N-1:0] ie;
    logic [LOG_N-1:0] half;
    logic [LOG_N-1:0] mask;
    logic [LOG_N-1:0] p;
    logic [LOG_N-1:0] a;
    ie   = {1'b0, bi};
    half = LOG_N'(1) << st;
    mask = half - LOG_N'(1);
    p    = ie & mask;
    a    = ((ie & ~mask) << 1) | p;
    gen  = {a, a | half, NH'(p << (LOG_N - 1 - int'(st)))};
  endfunction

  // Control FSM with registered, cycle-aligned read addresses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      s      <= '0;
      i      <= '0;
      d      <= '0;
      ra     <= '0;
      rb     <= '0;
      tw     <= '0;
      vq     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= RUN;
            s            <= '0;
            i            <= '0;
            {ra, rb, tw} <= gen('0, '0);
            vq           <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          if (!stl) begin
            if (i == '1) begin
              i     <= '0;
              d     <= '0;
              vq    <= 1'b0;
              state <= DRAIN;
            end else begin
              i            <= i + 1'b1;
              {ra, rb, tw} <= gen(s, i + 1'b1);
            end
          end
        end
        DRAIN: begin
          if (d == DW'(WR_LAT - 1)) begin
            if (s == SW'(LOG_N - 1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              s            <= s + 1'b1;
              state        <= RUN;
              vq           <= 1'b1;
              {ra, rb, tw} <= gen(s + 1'b1, '0);
            end
          end else begin
            d <= d + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line; keeps shifting so in-flight writes finish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wv <= '0;
      for (int k = 0; k < WR_LAT; k++) begin
        wa[k] <= '0;
        wb[k] <= '0;
      end
    end else begin
      wv[0] <= rv;
      wa[0] <= ra;
      wb[0] <= rb;
      for (int k = 1; k < WR_LAT; k++) begin
        wv[k] <= wv[k-1];
        wa[k] <= wa[k-1];
        wb[k] <= wb[k-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_addr_a = ra;
  assign bus.rd_addr_b = rb;
  assign bus.rd_valid  = rv;
  assign bus.tw_addr   = tw;
  assign bus.wr_addr_a = wa[WR_LAT-1];
  assign bus.wr_addr_b = wb[WR_LAT-1];
  assign bus.wr_en     = wv[WR_LAT-1];

endmodule

// File: tb/tb_fft_agu.sv
// Directed bench for fft_agu: LOG_N=11 address table, LOG_N=3 full run,
// held start, mid-run reset and (with FFT_AGU_STALL_EN) stall behaviour.
module tb_fft_agu;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_agu_if #(.LOG_N(11)) b11 ();
  fft_agu_if #(.LOG_N(3))  b3 ();

  fft_agu #(.LOG_N(11), .WR_LAT(2)) u11 (
    .clk(clk), .reset_n(reset_n), .bus(b11.slave)
  );
  fft_agu #(.LOG_N(3), .WR_LAT(2)) u3 (
    .clk(clk), .reset_n(reset_n), .bus(b3.slave)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    bit v;
    bit bz;
    bit dn;
    int a;
    int b;
    int tw;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  int e3a [12];
  int e3b [12];
  int e3t [12];

  task automatic run3(input bit hold);
    int nb, nv, nw, nd;
    nb = 0; nv = 0; nw = 0; nd = 0;
    @(negedge clk) b3.start = 1'b1;
    @(negedge clk);
    if (!hold) b3.start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      int st, j, r, wc;
      bit ev, ew;
      st = c / 6;
      j  = c % 6;
      r  = st * 4 + j;
      ev = (c < 18) && (j < 4);
      wc = c - 2;
      ew = (wc >= 0) && (wc < 18) && ((wc % 6) < 4);
      chk($sformatf("n3.valid c%0d", c), b3.rd_valid, ev);
      chk($sformatf("n3.busy c%0d", c), b3.busy, c < 18);
      chk($sformatf("n3.done c%0d", c), b3.done, c == 18);
      if (ev) begin
        chk($sformatf("n3.rda c%0d", c), b3.rd_addr_a, e3a[r]);
        chk($sformatf("n3.rdb c%0d", c), b3.rd_addr_b, e3b[r]);
        chk($sformatf("n3.tw c%0d", c), b3.tw_addr, e3t[r]);
      end
      chk($sformatf("n3.wr_en c%0d", c), b3.wr_en, ew);
      if (ew) begin
        chk($sformatf("n3.wra c%0d", c), b3.wr_addr_a,
            e3a[(wc / 6) * 4 + wc % 6]);
        chk($sformatf("n3.wrb c%0d", c), b3.wr_addr_b,
            e3b[(wc / 6) * 4 + wc % 6]);
      end
      nb += int'(b3.busy);
      nv += int'(b3.rd_valid);
      nw += int'(b3.wr_en);
      nd += int'(b3.done);
      if (c == 19) b3.start = 1'b0;
      @(negedge clk);
    end
    chk("n3.busy_cycles", nb, 18);
    chk("n3.rd_pulses", nv, 12);
    chk("n3.wr_pulses", nw, 12);
    chk("n3.done_pulses", nd, 1);
  endtask

  initial begin
    int idx;
    tbl[0]  = '{0,     1, 1, 0, 0,    1,    0};
    tbl[1]  = '{1,     1, 1, 0, 2,    3,    0};
    tbl[2]  = '{1023,  1, 1, 0, 2046, 2047, 0};
    tbl[3]  = '{1024,  0, 1, 0, -1,   -1,   -1};
    tbl[4]  = '{1025,  0, 1, 0, -1,   -1,   -1};
    tbl[5]  = '{1027,  1, 1, 0, 1,    3,    512};
    tbl[6]  = '{1028,  1, 1, 0, 4,    6,    0};
    tbl[7]  = '{3091,  1, 1, 0, 21,   29,   640};
    tbl[8]  = '{10265, 1, 1, 0, 5,    1029, 5};
    tbl[9]  = '{11283, 1, 1, 0, 1023, 2047, 1023};
    tbl[10] = '{11285, 0, 1, 0, -1,   -1,   -1};
    tbl[11] = '{11286, 0, 0, 1, -1,   -1,   -1};

    e3a = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    e3b = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    e3t = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    b11.start = 1'b0;
    b3.start  = 1'b0;
`ifdef FFT_AGU_STALL_EN
    b11.stall = 1'b0;
    b3.stall  = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("rst.busy", b11.busy, 0);
    chk("rst.valid", b11.rd_valid, 0);
    chk("rst.wr_en", b11.wr_en, 0);
    chk("rst.done", b11.done, 0);
    chk("rst.rda", b11.rd_addr_a, 0);

    reset_n   = 1'b1;
    b11.start = 1'b1;
    @(negedge clk);
    b11.start = 1'b0;
    idx = 0;
    for (int c = 0; c <= 11286; c++) begin
      while (idx < NV && tbl[idx].cyc == c) begin
        chk($sformatf("v11[%0d].valid", idx), b11.rd_valid, tbl[idx].v);
        chk($sformatf("v11[%0d].busy", idx), b11.busy, tbl[idx].bz);
        chk($sformatf("v11[%0d].done", idx), b11.done, tbl[idx].dn);
        if (tbl[idx].a >= 0) begin
          chk($sformatf("v11[%0d].rda", idx), b11.rd_addr_a, tbl[idx].a);
          chk($sformatf("v11[%0d].rdb", idx), b11.rd_addr_b, tbl[idx].b);
          chk($sformatf("v11[%0d].tw", idx), b11.tw_addr, tbl[idx].tw);
        end
        idx++;
      end
      @(negedge clk);
    end
    chk("v11.entries", idx, NV);

    run3(1'b0);
    run3(1'b1);

`ifdef FFT_AGU_STALL_EN
    begin
      int nb;
      @(negedge clk) b3.start = 1'b1;
      @(negedge clk) b3.start = 1'b0;
      chk("st.busy0", b3.busy, 1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 b3.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("st.valid k%0d", k), b3.rd_valid, 0);
        chk($sformatf("st.rda k%0d", k), b3.rd_addr_a, 4);
        chk($sformatf("st.rdb k%0d", k), b3.rd_addr_b, 5);
        chk($sformatf("st.busy k%0d", k), b3.busy, 1);
        chk($sformatf("st.wr_en k%0d", k), b3.wr_en, k < 2);
        if (k < 2)
          chk($sformatf("st.wra k%0d", k), b3.wr_addr_a, 2 * k);
        if (k < 2) begin
          @(posedge clk);
          #1;
        end
      end
      @(posedge clk);
      #1 b3.stall = 1'b0;
      @(negedge clk);
      chk("st.resume_valid", b3.rd_valid, 1);
      chk("st.resume_rda", b3.rd_addr_a, 4);
      chk("st.resume_wr_en", b3.wr_en, 0);
      nb = 0;
      for (int c = 0; c < 40 && !b3.done; c++) begin
        nb += int'(b3.busy);
        @(negedge clk);
      end
      chk("st.done_seen", b3.done, 1);
      chk("st.busy_tail", nb, 16);
      @(negedge clk);
    end
`endif

    @(negedge clk) b11.start = 1'b1;
    @(negedge clk) b11.start = 1'b0;
    repeat (2 * 1026 + 100) @(negedge clk);
    chk("rs.pre_rda", b11.rd_addr_a, 200);
    chk("rs.pre_rdb", b11.rd_addr_b, 204);
    chk("rs.pre_valid", b11.rd_valid, 1);
    chk("rs.pre_wr_en", b11.wr_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs.busy", b11.busy, 0);
    chk("rs.valid", b11.rd_valid, 0);
    chk("rs.wr_en", b11.wr_en, 0);
    chk("rs.done", b11.done, 0);
    chk("rs.rda", b11.rd_addr_a, 0);
    chk("rs.rdb", b11.rd_addr_b, 0);
    chk("rs.tw", b11.tw_addr, 0);
    chk("rs.wra", b11.wr_addr_a, 0);
    chk("rs.wrb", b11.wr_addr_b, 0);
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("rs.no_done c%0d", c), b11.done, 0);
      chk($sformatf("rs.idle c%0d", c), b11.busy, 0);
    end
    b11.start = 1'b1;
    @(negedge clk) b11.start = 1'b0;
    chk("rs.restart_valid", b11.rd_valid, 1);
    chk("rs.restart_rda", b11.rd_addr_a, 0);
    chk("rs.restart_rdb", b11.rd_addr_b, 1);
    chk("rs.restart_tw", b11.tw_addr, 0);
    @(negedge clk);
    chk("rs.restart_i1", b11.rd_addr_a, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
